// File: rtl/const_div_iter.sv
// ---------------------------------------------------------------------------
// const_div_iter
//   Iterative divide-by-constant unit. Produces the quotient and remainder of
//   a WIDTH-bit dividend by the fixed DIVISOR, retiring RADIX_BITS quotient
//   bits per cycle with the recurrence rem' = ({rem, chunk}) mod DIVISOR.
//   Each step uses a compare-subtract ladder against the constants
//   k*DIVISOR (k = 1 .. 2^RADIX_BITS-1); no divider is instantiated.
//
// Optional feature (macro CONST_DIV_SIGNED_EN):
//   defined   - in_signed=1 treats in_data as two's complement. The unit
//               divides the magnitude. The quotient is negated for a negative
//               dividend (truncation toward zero). The remainder carries the
//               dividend sign, so out_rem is RW+1 bits wide.
//   undefined - in_signed is ignored and out_rem is RW bits wide.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      dividend valid
//   in_ready   out  1      unit can accept a dividend (IDLE only)
//   in_data    in   WIDTH  dividend
//   in_signed  in   1      dividend is two's complement (signed build only)
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   out_quot   out  WIDTH  quotient
//   out_rem    out  ORW    remainder
//   dbg_state  out  2      FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and data) until that edge; ready never
// depends on valid in the same cycle.
// ---------------------------------------------------------------------------
module const_div_iter #(
    parameter int WIDTH      = 32,
    parameter int DIVISOR    = 5,
    parameter int RADIX_BITS = 2,
    localparam int RW        = $clog2(DIVISOR),
`ifdef CONST_DIV_SIGNED_EN
    localparam int ORW       = RW + 1
`else
    localparam int ORW       = RW
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [ORW-1:0]   out_rem,
    output logic [1:0]       dbg_state
);

    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int TW    = RW + RADIX_BITS;   // width of {rem, chunk}
    localparam int NK    = (1 << RADIX_BITS); // ladder has NK-1 rungs

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  quot_q,  quot_d;
    logic [RW-1:0]     rem_q,   rem_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  oquot_q, oquot_d;
    logic [ORW-1:0]    orem_q,  orem_d;

    // ------------------------------------------------------------------
    // One radix step: ladder over the constants k*DIVISOR. Because the
    // ladder is monotone the last rung that t clears gives the digit.
    // t < DIVISOR*2^R, so every constant and t fit in TW bits.
    // ------------------------------------------------------------------
    logic [TW-1:0]         t_val;
    logic [TW-1:0]         sub_val;
    logic [TW-1:0]         kd;
    logic [RADIX_BITS-1:0] digit;
    logic [RW-1:0]         rem_step;
    logic [WIDTH-1:0]      quot_step;

    always_comb begin
        t_val   = {rem_q, shift_q[WIDTH-1 -: RADIX_BITS]};
        sub_val = '0;
        digit   = '0;
        kd      = '0;
        for (int k = 1; k < NK; k++) begin
            kd = TW'(k * DIVISOR);
            if (t_val >= kd) begin
                digit   = RADIX_BITS'(k);
                sub_val = kd;
            end
        end
        rem_step  = RW'(t_val - sub_val);
        quot_step = (quot_q << RADIX_BITS) | WIDTH'(digit);
    end

    // ------------------------------------------------------------------
    // Operand capture and result fix-up
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] quot_fix;
    logic [ORW-1:0]   rem_fix;

`ifdef CONST_DIV_SIGNED_EN
    logic neg_q, neg_d;
    logic in_neg;

    // Negating 1<<(WIDTH-1) yields itself, which read unsigned is exactly
    // the required magnitude 2^(WIDTH-1).
    always_comb begin
        in_neg   = in_signed & in_data[WIDTH-1];
        mag      = in_neg ? (WIDTH'(0) - in_data) : in_data;
        quot_fix = neg_q ? (WIDTH'(0) - quot_step) : quot_step;
        rem_fix  = neg_q ? (ORW'(0) - {1'b0, rem_step}) : {1'b0, rem_step};
    end
`else
    logic unused_in_signed;
    assign unused_in_signed = in_signed;

    always_comb begin
        mag      = in_data;
        quot_fix = quot_step;
        rem_fix  = rem_step;
    end
`endif

    // ------------------------------------------------------------------
    // FSM next state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        oquot_d = oquot_q;
        orem_d  = orem_q;
`ifdef CONST_DIV_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    shift_d = mag;
                    quot_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(STEPS - 1);
`ifdef CONST_DIV_SIGNED_EN
                    neg_d   = in_neg;
`endif
                end
            end
            BUSY: begin
                shift_d = shift_q << RADIX_BITS;
                quot_d  = quot_step;
                rem_d   = rem_step;
                if (cnt_q == '0) begin
                    // Final step: result (with sign fix-up) lands in the
                    // output registers on the DONE entry edge.
                    state_d = DONE;
                    oquot_d = quot_fix;
                    orem_d  = rem_fix;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            oquot_q <= '0;
            orem_q  <= '0;
`ifdef CONST_DIV_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            oquot_q <= oquot_d;
            orem_q  <= orem_d;
`ifdef CONST_DIV_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_quot  = oquot_q;
    assign out_rem   = orem_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_const_div_iter.sv
module tb_const_div_iter;

    localparam int W   = 32;
    localparam int D   = 5;
    localparam int R   = 2;
    localparam int LAT = 16;
`ifdef CONST_DIV_SIGNED_EN
    localparam int ORW = 4;
`else
    localparam int ORW = 3;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_quot;
    logic [ORW-1:0] out_rem;
    logic [1:0]     dbg_state;

    int checks;
    int passed;

    const_div_iter #(
        .WIDTH      (W),
        .DIVISOR    (D),
        .RADIX_BITS (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Present a dividend and hold it until accepted; afterwards scramble
    // in_data/in_signed to show they are sampled only on accept.
    task automatic start_div(input logic [W-1:0] d, input logic s, output logic ok);
        int n;
        @(negedge clk);
        in_data  = d;
        in_signed = s;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    // Count cycles from the accept edge until out_valid appears.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_div(input logic [W-1:0] d, input logic s,
                           output logic [W-1:0] q, output logic [ORW-1:0] r,
                           output int lat);
        logic ok;
        start_div(d, s, ok);
        if (!ok) lat = -1;
        else wait_done(lat);
        q = out_quot;
        r = out_rem;
        finish_handshake();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_quot !== '0) $display("FAIL reset_out_quot: got %0d expected 0", out_quot); else passed++;
        checks++; if (out_rem !== '0) $display("FAIL reset_out_rem: got %0d expected 0", out_rem); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else passed++;
    endtask

    task automatic test_basic();
        logic [W-1:0] q;
        logic [ORW-1:0] r;
        int lat;
        run_div(32'd100, 1'b0, q, r, lat);
        checks++; if (lat !== LAT) $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); else passed++;
        checks++; if (q !== 32'd20) $display("FAIL basic_100_quot: got %0d expected 20", q); else passed++;
        checks++; if (r !== ORW'(0)) $display("FAIL basic_100_rem: got %0d expected 0", r); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_ready_after: got %b expected 1", in_ready); else passed++;
        run_div(32'd7, 1'b0, q, r, lat);
        checks++; if (q !== 32'd1) $display("FAIL basic_7_quot: got %0d expected 1", q); else passed++;
        checks++; if (r !== ORW'(2)) $display("FAIL basic_7_rem: got %0d expected 2", r); else passed++;
        run_div(32'd0, 1'b0, q, r, lat);
        checks++; if (q !== 32'd0 || r !== ORW'(0)) $display("FAIL basic_zero: got q=%0d r=%0d expected q=0 r=0", q, r); else passed++;
    endtask

    task automatic test_extremes();
        logic [W-1:0] q;
        logic [ORW-1:0] r;
        int lat;
        run_div(32'hFFFF_FFFF, 1'b0, q, r, lat);
        checks++; if (q !== 32'd858993459) $display("FAIL ext_allones_quot: got %0d expected 858993459", q); else passed++;
        checks++; if (r !== ORW'(0)) $display("FAIL ext_allones_rem: got %0d expected 0", r); else passed++;
        run_div(32'hFFFF_FFF9, 1'b0, q, r, lat);
        checks++; if (q !== 32'd858993457) $display("FAIL ext_fff9_quot: got %0d expected 858993457", q); else passed++;
        checks++; if (r !== ORW'(4)) $display("FAIL ext_fff9_rem: got %0d expected 4", r); else passed++;
        run_div(32'd4, 1'b0, q, r, lat);
        checks++; if (q !== 32'd0 || r !== ORW'(4)) $display("FAIL ext_4: got q=%0d r=%0d expected q=0 r=4", q, r); else passed++;
        run_div(32'd5, 1'b0, q, r, lat);
        checks++; if (q !== 32'd1 || r !== ORW'(0)) $display("FAIL ext_5: got q=%0d r=%0d expected q=1 r=0", q, r); else passed++;
    endtask

    task automatic test_backpressure();
        logic ok;
        int lat;
        start_div(32'd100, 1'b0, ok);
        wait_done(lat);
        checks++; if (lat !== LAT) $display("FAIL bp_latency: got %0d expected %0d", lat, LAT); else passed++;
        // new request held while the result is stalled must not be taken
        in_valid = 1'b1;
        in_data  = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_quot !== 32'd20 || out_rem !== ORW'(0) || in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: got v=%b q=%0d r=%0d rdy=%b expected v=1 q=20 r=0 rdy=0",
                         i, out_valid, out_quot, out_rem, in_ready);
            else passed++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_next: got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", out_valid); else passed++;
        @(negedge clk);
        checks++; if (dbg_state !== 2'd0) $display("FAIL bp_no_accept: got state %0d expected 0", dbg_state); else passed++;
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [W-1:0] q;
        logic [ORW-1:0] r;
        int lat;
        int seen;
        start_div(32'd100, 1'b0, ok);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmid_async: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); else passed++;
        checks++; if (out_quot !== '0 || out_rem !== '0) $display("FAIL rmid_clear: got q=%0d r=%0d expected 0 0", out_quot, out_rem); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rmid_no_result: got %0d valid cycles expected 0", seen); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", in_ready); else passed++;
        run_div(32'd12, 1'b0, q, r, lat);
        checks++; if (q !== 32'd2 || r !== ORW'(2)) $display("FAIL rmid_12: got q=%0d r=%0d expected q=2 r=2", q, r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL rmid_latency: got %0d expected %0d", lat, LAT); else passed++;
    endtask

    task automatic test_signed();
        logic [W-1:0] q;
        logic [ORW-1:0] r;
        int lat;
`ifdef CONST_DIV_SIGNED_EN
        run_div(32'hFFFF_FFF9, 1'b1, q, r, lat);
        checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL sgn_m7_quot: got %h expected ffffffff", q); else passed++;
        checks++; if (r !== 4'hE) $display("FAIL sgn_m7_rem: got %h expected e", r); else passed++;
        run_div(32'h8000_0000, 1'b1, q, r, lat);
        checks++; if (q !== 32'hE666_6667) $display("FAIL sgn_min_quot: got %h expected e6666667", q); else passed++;
        checks++; if (r !== 4'hD) $display("FAIL sgn_min_rem: got %h expected d", r); else passed++;
        checks++; if (lat !== LAT) $display("FAIL sgn_latency: got %0d expected %0d", lat, LAT); else passed++;
        run_div(32'd7, 1'b1, q, r, lat);
        checks++; if (q !== 32'd1 || r !== 4'd2) $display("FAIL sgn_pos7: got q=%0d r=%0d expected q=1 r=2", q, r); else passed++;
`else
        // in_signed has no effect in the unsigned build
        run_div(32'hFFFF_FFF9, 1'b1, q, r, lat);
        checks++; if (q !== 32'd858993457) $display("FAIL uns_ignore_quot: got %0d expected 858993457", q); else passed++;
        checks++; if (r !== 3'd4) $display("FAIL uns_ignore_rem: got %0d expected 4", r); else passed++;
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [ORW-1:0] r;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic signed [W-1:0] ds;
        logic s;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            if (i % 7 == 0) d = d & 32'h0000_00FF;
            s = 1'($urandom_range(0, 1));
            run_div(d, s, q, r, lat);
`ifdef CONST_DIV_SIGNED_EN
            if (s) begin
                ds = signed'(d);
                eq = W'(ds / D);
                er = W'(ds % D);
            end else begin
                eq = d / D;
                er = d % D;
            end
`else
            ds = signed'(d);
            eq = d / D;
            er = d % D;
`endif
            checks++;
            if (q !== eq || r !== er[ORW-1:0] || lat !== LAT) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_%0d d=%h s=%b: got q=%h r=%h lat=%0d expected q=%h r=%h lat=%0d",
                             i, d, s, q, r, lat, eq, er[ORW-1:0], LAT);
            end else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_signed();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
